pim_lut_gather_seq: RTL

- Sequencer and accumulator bank directly downstream of the PIM LUT compare stage.
- After a start pulse it steps the 4-bit accumulator index 0..15, one per cycle, into the LUT stage.
- It captures the returned 16-bit LUT result and its one-hot enable, and updates 16 local accumulators by overwrite or add.
- It presents the packed 256-bit bank to the PIM result path with a valid/ready handshake.

---
 rtl/pim_lut_gather_seq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pim_lut_gather_seq.sv
// rtl/pim_lut_gather_seq.sv - LUT index sequencer and 16-entry accumulator bank with valid/ready result.
// Optional build macro PIM_LUT_GATHER_SAT_EN: accumulate mode saturates at all-ones instead of wrapping.
module pim_lut_gather_seq #(
    parameter int NUM_ACC = 16,
    parameter int ACC_W   = 16,
    parameter int IDX_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst_x,
    input  logic                     i_start,
    input  logic [NUM_ACC-1:0]       i_mask,
    input  logic                     i_accumulate,
    input  logic                     i_clear,
    output logic [IDX_W-1:0]         o_acc_idx,
    input  logic [ACC_W-1:0]         i_lut_result,
    input  logic [NUM_ACC-1:0]       i_lut_result_enable,
    output logic                     o_busy,
    output logic [NUM_ACC*ACC_W-1:0] o_acc_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     scan_idx;
    logic [NUM_ACC-1:0]   mask_q;
    logic                 accum_q;
    logic                 err_q;
    logic [ACC_W-1:0]     acc [NUM_ACC];
    logic                 start_ok;
    logic                 clear_ok;
    logic                 in_scan;
    logic [NUM_ACC-1:0]   enable_exp;
    logic [ACC_W:0]       sum;
    logic [ACC_W-1:0]     add_val;
    logic [ACC_W-1:0]     new_val;

    assign start_ok = (state == ST_IDLE) && i_start;
    assign clear_ok = (state == ST_IDLE) && i_clear;
    assign in_scan  = (state == ST_SCAN);

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (i_start) state_nxt = ST_WAIT;
            ST_WAIT: state_nxt = ST_SCAN;
            ST_SCAN: if (scan_idx == IDX_W'(NUM_ACC - 1)) state_nxt = ST_DONE;
            ST_DONE: if (i_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The index counter sits at zero outside SCAN, so it doubles as the LUT index output.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            scan_idx <= '0;
        end else if (in_scan) begin
            scan_idx <= scan_idx + IDX_W'(1);
        end else begin
            scan_idx <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            mask_q  <= '0;
            accum_q <= 1'b0;
        end else if (start_ok) begin
            mask_q  <= i_mask;
            accum_q <= i_accumulate;
        end
    end

    assign enable_exp = {{(NUM_ACC-1){1'b0}}, 1'b1} << scan_idx;

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            err_q <= 1'b0;
        end else if (in_scan && (i_lut_result_enable != enable_exp)) begin
            err_q <= 1'b1;
        end
    end

    always_comb begin
        sum = {1'b0, acc[scan_idx]} + {1'b0, i_lut_result};
`ifdef PIM_LUT_GATHER_SAT_EN
        add_val = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        add_val = sum[ACC_W-1:0];
`endif
        new_val = accum_q ? add_val : i_lut_result;
    end

    // Clear has priority; it can only coincide with a start, never with a scan write.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            for (int k = 0; k < NUM_ACC; k++) acc[k] <= '0;
        end else if (clear_ok) begin
            for (int k = 0; k < NUM_ACC; k++) acc[k] <= '0;
        end else if (in_scan && mask_q[scan_idx]) begin
            acc[scan_idx] <= new_val;
        end
    end

    for (genvar g = 0; g < NUM_ACC; g++) begin : g_pack
        assign o_acc_data[g*ACC_W +: ACC_W] = acc[g];
    end

    assign o_acc_idx = scan_idx;
    assign o_busy    = (state != ST_IDLE);
    assign o_valid   = (state == ST_DONE);
    assign o_err     = err_q;

endmodule
